// File: rtl/reservation_station_if.sv
// Dispatch, CDB snoop and ALU-issue signal bundle for the reservation station.
// Master side is the dispatcher/ROB/CDB environment; slave side is the station.
// full_to_dispatch is the only backpressure signal; in_valid while full is dropped.
interface reservation_station_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int TAG_W  = 4
);
  logic              rollback;
  logic              in_valid;
  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_v1;
  logic [DATA_W-1:0] in_v2;
  logic              in_r1;
  logic              in_r2;
  logic [TAG_W-1:0]  in_q1;
  logic [TAG_W-1:0]  in_q2;
  logic [DATA_W-1:0] in_imm;
  logic [DATA_W-1:0] in_pc;
  logic [TAG_W-1:0]  in_tag;
  logic              full_to_dispatch;
  logic              alu_cdb_valid;
  logic [TAG_W-1:0]  alu_cdb_tag;
  logic [DATA_W-1:0] alu_cdb_data;
  logic              lsb_cdb_valid;
  logic [TAG_W-1:0]  lsb_cdb_tag;
  logic [DATA_W-1:0] lsb_cdb_data;
  logic [OP_W-1:0]   op_to_alu;
  logic [DATA_W-1:0] v1_to_alu;
  logic [DATA_W-1:0] v2_to_alu;
  logic [DATA_W-1:0] imm_to_alu;
  logic [DATA_W-1:0] pc_to_alu;
  logic              is_empty_to_alu;
  logic [TAG_W-1:0]  tag_to_rob;

  modport master (
    output rollback, in_valid, in_op, in_v1, in_v2, in_r1, in_r2, in_q1, in_q2,
           in_imm, in_pc, in_tag,
           alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
           lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data,
    input  full_to_dispatch, op_to_alu, v1_to_alu, v2_to_alu, imm_to_alu,
           pc_to_alu, is_empty_to_alu, tag_to_rob
  );

  modport slave (
    input  rollback, in_valid, in_op, in_v1, in_v2, in_r1, in_r2, in_q1, in_q2,
           in_imm, in_pc, in_tag,
           alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
           lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data,
    output full_to_dispatch, op_to_alu, v1_to_alu, v2_to_alu, imm_to_alu,
           pc_to_alu, is_empty_to_alu, tag_to_rob
  );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched ops, snoops ALU/LSB CDBs, issues one ready op per cycle.
// Latency: ready-at-dispatch op issues at the edge after its write; CDB wakeup at edge N issues at N+1.
// Backpressure: full_to_dispatch when all entries hold ops; in_valid while full is dropped.
module reservation_station #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int TAG_W  = 4
) (
  input logic               clk,
  input logic               rst,
  reservation_station_if.slave rs
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  r1;
  logic [DEPTH-1:0]  r2;
  logic [OP_W-1:0]   op   [DEPTH];
  logic [DATA_W-1:0] v1   [DEPTH];
  logic [DATA_W-1:0] v2   [DEPTH];
  logic [TAG_W-1:0]  q1   [DEPTH];
  logic [TAG_W-1:0]  q2   [DEPTH];
  logic [DATA_W-1:0] imm  [DEPTH];
  logic [DATA_W-1:0] pc   [DEPTH];
  logic [TAG_W-1:0]  tag  [DEPTH];
  logic [CNT_W-1:0]  count;

  logic              has_free, has_iss, do_disp;
  logic [IDX_W-1:0]  free_idx, iss_idx;
  logic [DEPTH-1:0]  w1_hit, w2_hit;
  logic [DATA_W-1:0] w1_dat [DEPTH];
  logic [DATA_W-1:0] w2_dat [DEPTH];
  logic              b1_hit, b2_hit;
  logic [DATA_W-1:0] b1_dat, b2_dat;

  // ALU broadcast takes precedence when both buses carry the wanted tag.
  function automatic logic [DATA_W:0] snoop(
    input logic [TAG_W-1:0]  q,
    input logic              av,
    input logic [TAG_W-1:0]  at,
    input logic [DATA_W-1:0] ad,
    input logic              lv,
    input logic [TAG_W-1:0]  lt,
    input logic [DATA_W-1:0] ld
  );
    if (av && at == q)      return {1'b1, ad};
    else if (lv && lt == q) return {1'b1, ld};
    else                    return {1'b0, {DATA_W{1'b0}}};
  endfunction

  // Lowest free slot and lowest ready slot, both from registered state only.
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    has_iss  = 1'b0;
    iss_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (valid[i] && r1[i] && r2[i]) begin
        has_iss = 1'b1;
        iss_idx = IDX_W'(i);
      end
    end
  end

  // CDB snoop for every stored entry and for the op being dispatched.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {w1_hit[i], w1_dat[i]} = snoop(q1[i], rs.alu_cdb_valid, rs.alu_cdb_tag, rs.alu_cdb_data,
                                     rs.lsb_cdb_valid, rs.lsb_cdb_tag, rs.lsb_cdb_data);
      {w2_hit[i], w2_dat[i]} = snoop(q2[i], rs.alu_cdb_valid, rs.alu_cdb_tag, rs.alu_cdb_data,
                                     rs.lsb_cdb_valid, rs.lsb_cdb_tag, rs.lsb_cdb_data);
    end
    {b1_hit, b1_dat} = snoop(rs.in_q1, rs.alu_cdb_valid, rs.alu_cdb_tag, rs.alu_cdb_data,
                             rs.lsb_cdb_valid, rs.lsb_cdb_tag, rs.lsb_cdb_data);
    {b2_hit, b2_dat} = snoop(rs.in_q2, rs.alu_cdb_valid, rs.alu_cdb_tag, rs.alu_cdb_data,
                             rs.lsb_cdb_valid, rs.lsb_cdb_tag, rs.lsb_cdb_data);
  end

  assign rs.full_to_dispatch = (count == CNT_W'(DEPTH));
  assign do_disp = rs.in_valid && !rs.full_to_dispatch && has_free;

  // Entry storage, wakeup, issue and dispatch; rollback overrides all of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      r1    <= '0;
      r2    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op[i]  <= '0;
        v1[i]  <= '0;
        v2[i]  <= '0;
        q1[i]  <= '0;
        q2[i]  <= '0;
        imm[i] <= '0;
        pc[i]  <= '0;
        tag[i] <= '0;
      end
      rs.op_to_alu       <= '0;
      rs.v1_to_alu       <= '0;
      rs.v2_to_alu       <= '0;
      rs.imm_to_alu      <= '0;
      rs.pc_to_alu       <= '0;
      rs.tag_to_rob      <= '0;
      rs.is_empty_to_alu <= 1'b1;
    end else if (rs.rollback) begin
      valid              <= '0;
      count              <= '0;
      rs.is_empty_to_alu <= 1'b1;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && !r1[i] && w1_hit[i]) begin
          r1[i] <= 1'b1;
          v1[i] <= w1_dat[i];
        end
        if (valid[i] && !r2[i] && w2_hit[i]) begin
          r2[i] <= 1'b1;
          v2[i] <= w2_dat[i];
        end
      end
      if (has_iss) begin
        valid[iss_idx]     <= 1'b0;
        rs.op_to_alu       <= op[iss_idx];
        rs.v1_to_alu       <= v1[iss_idx];
        rs.v2_to_alu       <= v2[iss_idx];
        rs.imm_to_alu      <= imm[iss_idx];
        rs.pc_to_alu       <= pc[iss_idx];
        rs.tag_to_rob      <= tag[iss_idx];
        rs.is_empty_to_alu <= 1'b0;
      end else begin
        rs.is_empty_to_alu <= 1'b1;
      end
      if (do_disp) begin
        valid[free_idx] <= 1'b1;
        op[free_idx]    <= rs.in_op;
        imm[free_idx]   <= rs.in_imm;
        pc[free_idx]    <= rs.in_pc;
        tag[free_idx]   <= rs.in_tag;
        q1[free_idx]    <= rs.in_q1;
        q2[free_idx]    <= rs.in_q2;
        r1[free_idx]    <= rs.in_r1 || b1_hit;
        r2[free_idx]    <= rs.in_r2 || b2_hit;
        v1[free_idx]    <= (!rs.in_r1 && b1_hit) ? b1_dat : rs.in_v1;
        v2[free_idx]    <= (!rs.in_r2 && b2_hit) ? b2_dat : rs.in_v2;
      end
      count <= count + CNT_W'(do_disp) - CNT_W'(has_iss);
    end
  end
endmodule
